// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: drives the req/ready/rvalid handshake for loads and
// stores from the EX/MEM bundle, stalls upstream while busy, and produces the MEM/WB bundle.
module mem_access_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wreg_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_wreg_addr,
  output logic              wb_reg_write,
  output logic              err_misalign,
  output logic              err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_WAIT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0]   wreg_q, wreg_d;
  logic                we_q, we_d;
  logic                rw_q, rw_d;
  logic                m2r_q, m2r_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [REG_AW-1:0]   wb_wreg_q, wb_wreg_d;
  logic                wb_rw_q, wb_rw_d;
  logic                err_mis_q, err_mis_d;
  logic                err_to_q, err_to_d;

  logic memop, aligned, store_done, load_done;

  assign memop   = ex_valid & (ex_mem_read | ex_mem_write);
  assign aligned = (ex_alu_result[1:0] == 2'b00);

  assign store_done = (state_q == S_REQ) & dm_ready & we_q;
  assign load_done  = dm_rvalid & (((state_q == S_REQ) & dm_ready & ~we_q) | (state_q == S_WAIT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wreg_d     = wreg_q;
    we_d       = we_q;
    rw_d       = rw_q;
    m2r_d      = m2r_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_data_d  = wb_data_q;
    wb_wreg_d  = wb_wreg_q;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_valid && !memop) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ex_alu_result;
          wb_wreg_d  = ex_wreg_addr;
          wb_rw_d    = ex_reg_write;
        end else if (memop && !aligned) begin
          err_mis_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_wreg_d  = ex_wreg_addr;
        end else if (memop) begin
          addr_d  = ex_alu_result;
          wdata_d = ex_store_data;
          wreg_d  = ex_wreg_addr;
          // read wins when both read and write are flagged
          we_d    = ex_mem_write & ~ex_mem_read;
          rw_d    = ex_reg_write;
          m2r_d   = ex_mem_to_reg;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (store_done) begin
          wb_valid_d = 1'b1;
          wb_wreg_d  = wreg_q;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else if (load_done) begin
          wb_valid_d = 1'b1;
          wb_data_d  = m2r_q ? dm_rdata : addr_q;
          wb_wreg_d  = wreg_q;
          wb_rw_d    = rw_q;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (state_q == S_REQ && dm_ready) state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wreg_q     <= '0;
      we_q       <= 1'b0;
      rw_q       <= 1'b0;
      m2r_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_wreg_q  <= '0;
      wb_rw_q    <= 1'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wreg_q     <= wreg_d;
      we_q       <= we_d;
      rw_q       <= rw_d;
      m2r_q      <= m2r_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_rw_q    <= wb_rw_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  // RSTn gating keeps the handshake and stall quiet while reset is held with a live bundle
  assign dm_req    = RSTn & (state_q == S_REQ);
  assign dm_we     = RSTn & (state_q == S_REQ) & we_q;
  assign dm_addr   = {addr_q[DATA_W-1:2], 2'b00};
  assign dm_wdata  = wdata_q;
  assign mem_stall = RSTn & ((state_q != S_IDLE) | (memop & aligned));

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_wreg_addr = wb_wreg_q;
  assign wb_reg_write = wb_rw_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed transactions plus random transactions checked
// against a transaction-level latency/result model; hand-written reset-abort sequences.
module tb_mem_access_unit;

  localparam int unsigned MAXW = 15;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_wreg_addr;
  logic        dm_req, dm_we, dm_ready, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, wb_valid, wb_reg_write, err_misalign, err_timeout;
  logic [31:0] wb_data;
  logic [4:0]  wb_wreg_addr;

  mem_access_unit #(.DATA_W(32), .REG_AW(5), .MAX_WAIT(15)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_wreg_addr(ex_wreg_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_wreg_addr(wb_wreg_addr), .wb_reg_write(wb_reg_write),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit rd, wr, rw, m2r;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  wreg;
    int unsigned r, v;
  } txn_t;

  typedef struct {
    bit valid, mis, tmo, rw;
    int unsigned lat;
    logic [31:0] data;
  } exp_t;

  typedef struct { txn_t t; exp_t e; } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Outcome from the rules: completion edge counted from the latch edge, timeout at MAXW.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int unsigned done;
    e = '{valid: 0, mis: 0, tmo: 0, rw: 0, lat: 0, data: '0};
    if (!(t.rd || t.wr)) begin
      e.valid = 1; e.data = t.addr; e.rw = t.rw;
    end else if (t.addr[1:0] != 2'b00) begin
      e.valid = 1; e.mis = 1;
    end else begin
      done = t.rd ? t.r + 1 + t.v : t.r + 1;
      if (done <= MAXW) begin
        e.valid = 1; e.lat = done;
        e.rw    = t.rd ? t.rw : 1'b0;
        e.data  = (t.rd && t.m2r) ? t.rdata : t.addr;
      end else begin
        e.tmo = 1; e.lat = MAXW;
      end
    end
    return e;
  endfunction

  function automatic txn_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] wreg, input bit rw,
                              input bit m2r, input int unsigned r, input int unsigned v,
                              input logic [31:0] rdata);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.wreg = wreg;
    t.rw = rw; t.m2r = m2r; t.r = r; t.v = v; t.rdata = rdata;
    return t;
  endfunction

  function automatic exp_t ex(input bit valid, input bit mis, input bit tmo, input bit rw,
                              input int unsigned lat, input logic [31:0] data);
    exp_t e;
    e.valid = valid; e.mis = mis; e.tmo = tmo; e.rw = rw; e.lat = lat; e.data = data;
    return e;
  endfunction

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_alu_result = $urandom;
    ex_store_data = $urandom;
    ex_wreg_addr  = 5'($urandom);
    ex_reg_write  = 1'($urandom);
    ex_mem_read   = 1'($urandom);
    ex_mem_write  = 1'($urandom);
    ex_mem_to_reg = 1'($urandom);
  endtask

  task automatic run_txn(input txn_t t, input exp_t e);
    bit memok, is_store;
    memok    = (t.rd || t.wr) && (t.addr[1:0] == 2'b00);
    is_store = t.wr && !t.rd;
    ex_valid = 1'b1; ex_alu_result = t.addr; ex_store_data = t.wdata; ex_wreg_addr = t.wreg;
    ex_reg_write = t.rw; ex_mem_read = t.rd; ex_mem_write = t.wr; ex_mem_to_reg = t.m2r;
    dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
    #1;
    chk("stall_issue", 32'(mem_stall), 32'(memok));
    chk("req_issue", 32'(dm_req), 32'd0);
    for (int unsigned j = 0; j <= e.lat; j++) begin
      if (j > 0) begin
        idle_inputs();
        dm_ready  = (j == t.r + 1);
        dm_rvalid = t.rd && (j == t.r + 1 + t.v);
        dm_rdata  = dm_rvalid ? t.rdata : $urandom;
        #1;
        chk("req_busy", 32'(dm_req), 32'(j <= t.r + 1));
        chk("stall_busy", 32'(mem_stall), 32'd1);
        if (j <= t.r + 1) begin
          chk("dm_addr", dm_addr, t.addr);
          chk("dm_we", 32'(dm_we), 32'(is_store));
          if (is_store) chk("dm_wdata", dm_wdata, t.wdata);
        end
      end
      tick();
      chk("wb_valid", 32'(wb_valid), 32'((j == e.lat) && e.valid));
      chk("err_misalign", 32'(err_misalign), 32'((j == e.lat) && e.mis));
      chk("err_timeout", 32'(err_timeout), 32'((j == e.lat) && e.tmo));
      if (j == e.lat && e.valid) begin
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        if (!e.mis && !is_store) begin
          chk("wb_data", wb_data, e.data);
          chk("wb_wreg_addr", 32'(wb_wreg_addr), 32'(t.wreg));
        end
      end
    end
    idle_inputs();
    dm_ready = 1'b0; dm_rvalid = 1'b0;
    #1;
    chk("stall_after", 32'(mem_stall), 32'd0);
    chk("req_after", 32'(dm_req), 32'd0);
    tick();
    chk("pulse_end", 32'({wb_valid, err_misalign, err_timeout}), 32'd0);
  endtask

  task automatic reset_abort(input bit in_wait);
    ex_valid = 1'b1; ex_alu_result = 32'h40; ex_store_data = 32'h0; ex_wreg_addr = 5'd4;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b1;
    dm_ready = 1'b0; dm_rvalid = 1'b0;
    tick();
    idle_inputs();
    dm_ready = in_wait;
    tick();
    dm_ready = 1'b0;
    #1;
    chk("rst_pre_req", 32'(dm_req), 32'(!in_wait));
    chk("rst_pre_stall", 32'(mem_stall), 32'd1);
    #1 RSTn = 1'b0;
    #1;
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wb", 32'({wb_valid, wb_reg_write, err_misalign, err_timeout}), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    tick();
    RSTn = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
    #1;
    chk("late_rv_req", 32'(dm_req), 32'd0);
    tick();
    chk("late_rv_wb", 32'(wb_valid), 32'd0);
    chk("late_rv_data", wb_data, 32'd0);
    dm_rvalid = 1'b0;
    #1;
    chk("late_rv_stall", 32'(mem_stall), 32'd0);
    tick();
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{mk(0,0,32'h1234,32'h0,5'd5,1,0,0,0,32'h0),                ex(1,0,0,1,0,32'h1234)};
    tbl[1]  = '{mk(0,1,32'h100,32'hDEADBEEF,5'd1,1,0,2,0,32'h0),           ex(1,0,0,0,3,32'h0)};
    tbl[2]  = '{mk(1,0,32'h200,32'h0,5'd7,1,1,0,2,32'hCAFEF00D),           ex(1,0,0,1,3,32'hCAFEF00D)};
    tbl[3]  = '{mk(1,0,32'h203,32'h0,5'd8,1,1,0,0,32'h0),                  ex(1,1,0,0,0,32'h0)};
    tbl[4]  = '{mk(1,0,32'h300,32'h0,5'd2,1,1,0,99,32'h0),                 ex(0,0,1,0,15,32'h0)};
    tbl[5]  = '{mk(1,0,32'h4,32'h0,5'd3,1,1,0,0,32'h11112222),             ex(1,0,0,1,1,32'h11112222)};
    tbl[6]  = '{mk(1,0,32'h8,32'h0,5'd9,1,0,1,1,32'hFFFF0000),             ex(1,0,0,1,3,32'h8)};
    tbl[7]  = '{mk(0,1,32'h500,32'h12345678,5'd6,1,0,14,0,32'h0),          ex(1,0,0,0,15,32'h0)};
    tbl[8]  = '{mk(0,1,32'h504,32'h87654321,5'd6,1,0,15,0,32'h0),          ex(0,0,1,0,15,32'h0)};
    tbl[9]  = '{mk(1,1,32'h10,32'h99999999,5'd10,1,1,0,1,32'hA5A5A5A5),    ex(1,0,0,1,2,32'hA5A5A5A5)};
    tbl[10] = '{mk(0,0,32'h7,32'h0,5'd31,0,0,0,0,32'h0),                   ex(1,0,0,0,0,32'h7)};
    tbl[11] = '{mk(0,1,32'h102,32'h55555555,5'd11,1,0,0,0,32'h0),          ex(1,1,0,0,0,32'h0)};
    tbl[12] = '{mk(1,0,32'h600,32'h0,5'd12,1,1,13,1,32'h0BADCAFE),         ex(1,0,0,1,15,32'h0BADCAFE)};

    RSTn = 1'b0;
    ex_valid = 1'b1; ex_alu_result = 32'h80; ex_store_data = '0; ex_wreg_addr = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0;
    dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    tick();
    tick();
    chk("reset_req", 32'(dm_req), 32'd0);
    chk("reset_we", 32'(dm_we), 32'd0);
    chk("reset_stall", 32'(mem_stall), 32'd0);
    chk("reset_wb", 32'({wb_valid, wb_reg_write, err_misalign, err_timeout}), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_wb_wreg", 32'(wb_wreg_addr), 32'd0);
    idle_inputs();
    RSTn = 1'b1;
    tick();

    for (int unsigned i = 0; i < 13; i++) run_txn(tbl[i].t, tbl[i].e);

    reset_abort(1'b0);
    reset_abort(1'b1);

    for (int unsigned n = 0; n < 40; n++) begin
      txn_t t;
      int unsigned kind;
      kind    = $urandom_range(0, 3);
      t.rd    = (kind == 1) || (kind == 3);
      t.wr    = (kind == 2) || (kind == 3);
      t.addr  = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.wreg  = 5'($urandom);
      t.rw    = 1'($urandom);
      t.m2r   = 1'($urandom);
      t.r     = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 3);
      t.v     = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 14) : $urandom_range(0, 3);
      run_txn(t, model(t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
